// File: rtl/decode_pkg.sv
// Shared encodings and the decoded-instruction record for the RESTC_U decode stage.
// The optional M-extension decode is enabled with the RESTC_DECODE_M_EXT_EN macro.
package decode_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_NOP  = 4'b1110
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_NT  = 3'b010,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_e;

  typedef enum logic [2:0] {
    SEXT_I   = 3'b000,
    SEXT_B   = 3'b001,
    SEXT_JAL = 3'b010,
    SEXT_U   = 3'b011,
    SEXT_S   = 3'b110
  } sext_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b11
  } wb_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_ctrl_e  alu_ctrl;
    branch_e    branch;
    logic [2:0] ls_type;
    sext_e      sext_type;
    wb_e        wb_ctrl;
    logic       jump;
    logic       jump_type;
    logic       alu_src1;
    logic       alu_src2;
    logic       we_reg;
    logic       we_mem;
    logic       illegal;
    logic       md_valid;
    logic [2:0] md_op;
  } decode_t;

  // Inert record: bubbles, illegal instructions and reset all start from this.
  localparam decode_t DECODE_NOP = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    alu_ctrl: ALU_NOP, branch: BR_NT, ls_type: 3'd0,
    sext_type: SEXT_I, wb_ctrl: WB_ALU,
    jump: 1'b0, jump_type: 1'b0, alu_src1: 1'b0, alu_src2: 1'b0,
    we_reg: 1'b0, we_mem: 1'b0, illegal: 1'b0,
    md_valid: 1'b0, md_op: 3'd0
  };

  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_ctrl_e res;
    case (f3)
      3'b000:  res = alt ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = alt ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/decode_stage_core.sv
// Purely combinational RV32I (+ optional M, macro RESTC_DECODE_M_EXT_EN) decoder.
// Illegal encodings collapse to the inert NOP record with only the illegal flag set.
module decode_core
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];
  assign rd_f  = instr[11:7];

  always_comb begin
    dec = DECODE_NOP;
    case (instr[6:0])
      OP_LUI: begin
        dec.rd        = rd_f;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src2  = 1'b1;
        dec.sext_type = SEXT_U;
        dec.we_reg    = 1'b1;
      end
      OP_AUIPC: begin
        dec.rd        = rd_f;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 1'b1;
        dec.sext_type = SEXT_U;
        dec.we_reg    = 1'b1;
      end
      OP_JAL: begin
        dec.rd        = rd_f;
        dec.jump      = 1'b1;
        dec.jump_type = 1'b1;
        dec.wb_ctrl   = WB_LINK;
        dec.sext_type = SEXT_JAL;
        dec.we_reg    = 1'b1;
      end
      OP_JALR: begin
        if (f3 != 3'b000) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1     = rs1_f;
          dec.rd      = rd_f;
          dec.jump    = 1'b1;
          dec.wb_ctrl = WB_LINK;
          dec.we_reg  = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (f3[2:1] == 2'b01) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1       = rs1_f;
          dec.rs2       = rs2_f;
          dec.branch    = branch_e'(f3);
          dec.sext_type = SEXT_B;
        end
      end
      OP_LOAD: begin
        if (f3 == 3'b011 || f3[2:1] == 2'b11) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1      = rs1_f;
          dec.rd       = rd_f;
          dec.alu_ctrl = ALU_ADD;
          dec.alu_src2 = 1'b1;
          dec.wb_ctrl  = WB_LOAD;
          dec.we_reg   = 1'b1;
          dec.ls_type  = f3;
        end
      end
      OP_STORE: begin
        if (f3 > 3'b010) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1       = rs1_f;
          dec.rs2       = rs2_f;
          dec.alu_ctrl  = ALU_ADD;
          dec.alu_src2  = 1'b1;
          dec.we_mem    = 1'b1;
          dec.ls_type   = f3;
          dec.sext_type = SEXT_S;
        end
      end
      OP_IMM: begin
        // Only the shift-immediate forms constrain the upper bits.
        if ((f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) begin
          dec.illegal = 1'b1;
        end else begin
          dec.rs1      = rs1_f;
          dec.rd       = rd_f;
          dec.alu_ctrl = alu_from_funct3(f3, (f3 == 3'b101) && f7[5]);
          dec.alu_src2 = 1'b1;
          dec.we_reg   = 1'b1;
        end
      end
      OP_REG: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec.rs1      = rs1_f;
          dec.rs2      = rs2_f;
          dec.rd       = rd_f;
          dec.alu_ctrl = alu_from_funct3(f3, f7[5]);
          dec.we_reg   = 1'b1;
        end
`ifdef RESTC_DECODE_M_EXT_EN
        else if (f7 == 7'h01) begin
          dec.rs1      = rs1_f;
          dec.rs2      = rs2_f;
          dec.rd       = rd_f;
          dec.we_reg   = 1'b1;
          dec.md_valid = 1'b1;
          dec.md_op    = f3;
        end
`endif
        else begin
          dec.illegal = 1'b1;
        end
      end
      // The all-zero word is the pipeline bubble, not an illegal instruction.
      default: dec.illegal = (instr != 32'h0000_0000);
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: DEPTH-entry fetch queue, combinational head decode, registered output slot.
// M-extension decode is compiled in when RESTC_DECODE_M_EXT_EN is defined.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [3:0]             out_alu_ctrl,
  output logic [2:0]             out_branch,
  output logic [2:0]             out_ls_type,
  output logic [2:0]             out_sext_type,
  output logic [1:0]             out_wb_ctrl,
  output logic                   out_jump,
  output logic                   out_jump_type,
  output logic                   out_alu_src1,
  output logic                   out_alu_src2,
  output logic                   out_we_reg,
  output logic                   out_we_mem,
  output logic                   out_illegal,
  output logic                   out_md_valid,
  output logic [2:0]             out_md_op,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on occupancy; the slot holds steady while out_valid && !out_ready.

  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q    [DEPTH];

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  decode_t         slot_q, slot_d;
  logic [PC_W-1:0] slot_pc_q, slot_pc_d;

  logic            enq;
  logic            deq;
  decode_t         head_dec;

  decode_core u_core (
    .instr (instr_mem_q[rd_ptr_q]),
    .dec   (head_dec)
  );

  assign in_ready = (count_q != CW'(DEPTH));
  assign enq      = in_valid && in_ready && !flush;
  assign deq      = (count_q != '0) && (!out_valid_q || out_ready) && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    slot_pc_d   = slot_pc_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      slot_d      = DECODE_NOP;
      slot_pc_d   = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (deq) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_valid_d = 1'b1;
        slot_d      = head_dec;
        slot_pc_d   = pc_mem_q[rd_ptr_q];
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      slot_q      <= DECODE_NOP;
      slot_pc_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
      slot_pc_q   <= slot_pc_d;
    end
  end

  // Queue storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign count         = count_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = slot_pc_q;
  assign out_rs1       = slot_q.rs1;
  assign out_rs2       = slot_q.rs2;
  assign out_rd        = slot_q.rd;
  assign out_alu_ctrl  = slot_q.alu_ctrl;
  assign out_branch    = slot_q.branch;
  assign out_ls_type   = slot_q.ls_type;
  assign out_sext_type = slot_q.sext_type;
  assign out_wb_ctrl   = slot_q.wb_ctrl;
  assign out_jump      = slot_q.jump;
  assign out_jump_type = slot_q.jump_type;
  assign out_alu_src1  = slot_q.alu_src1;
  assign out_alu_src2  = slot_q.alu_src2;
  assign out_we_reg    = slot_q.we_reg;
  assign out_we_mem    = slot_q.we_mem;
  assign out_illegal   = slot_q.illegal;
  assign out_md_valid  = slot_q.md_valid;
  assign out_md_op     = slot_q.md_op;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int FW    = 41;
  localparam int W     = PC_W + FW;
`ifdef RESTC_DECODE_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef logic [W-1:0] vec_t;
  localparam logic [FW-1:0] RESET_FIELDS = {15'd0, 4'b1110, 3'b010, 3'd0, 3'd0, 2'd0, 8'd0, 3'd0};

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [3:0]      out_alu_ctrl;
  logic [2:0]      out_branch, out_ls_type, out_sext_type;
  logic [1:0]      out_wb_ctrl;
  logic            out_jump, out_jump_type, out_alu_src1, out_alu_src2;
  logic            out_we_reg, out_we_mem, out_illegal, out_md_valid;
  logic [2:0]      out_md_op;
  logic [$clog2(DEPTH):0] count;

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_alu_ctrl(out_alu_ctrl), .out_branch(out_branch), .out_ls_type(out_ls_type),
    .out_sext_type(out_sext_type), .out_wb_ctrl(out_wb_ctrl),
    .out_jump(out_jump), .out_jump_type(out_jump_type),
    .out_alu_src1(out_alu_src1), .out_alu_src2(out_alu_src2),
    .out_we_reg(out_we_reg), .out_we_mem(out_we_mem), .out_illegal(out_illegal),
    .out_md_valid(out_md_valid), .out_md_op(out_md_op), .count(count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int   checks   = 0;
  int   failures = 0;
  logic [W-1:0] exp_q[$];

  logic [FW-1:0] dut_fields;
  assign dut_fields = {out_rs1, out_rs2, out_rd, out_alu_ctrl, out_branch, out_ls_type,
                       out_sext_type, out_wb_ctrl, out_jump, out_jump_type, out_alu_src1,
                       out_alu_src2, out_we_reg, out_we_mem, out_illegal, out_md_valid, out_md_op};

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8];
    tbl = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h4, 4'h8, 4'h3, 4'h2};
    if (alt && f3 == 3'd0) return 4'h1;
    if (alt && f3 == 3'd5) return 4'h9;
    return tbl[f3];
  endfunction

  function automatic logic [FW-1:0] ref_decode(input logic [31:0] ins);
    logic [6:0] op, f7;
    logic [2:0] f3, br, ls, sx, mo;
    logic [4:0] rs1, rs2, rd;
    logic [3:0] alu;
    logic [1:0] wb;
    logic jmp, jt, s1, s2, wr, wm, ill, mv, use1, use2, used;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    alu = 4'he; br = 3'b010; ls = 3'd0; sx = 3'd0; wb = 2'd0; mo = 3'd0;
    {jmp, jt, s1, s2, wr, wm, ill, mv} = 8'd0;
    {use1, use2, used} = 3'd0;
    case (op)
      7'h37: begin used = 1; alu = 4'h0; s2 = 1; sx = 3'd3; wr = 1; end
      7'h17: begin used = 1; alu = 4'h0; s1 = 1; s2 = 1; sx = 3'd3; wr = 1; end
      7'h6f: begin used = 1; jmp = 1; jt = 1; wb = 2'd3; sx = 3'd2; wr = 1; end
      7'h67: begin ill = (f3 != 0); use1 = 1; used = 1; jmp = 1; wb = 2'd3; wr = 1; end
      7'h63: begin ill = (f3 == 2 || f3 == 3); use1 = 1; use2 = 1; br = f3; sx = 3'd1; end
      7'h03: begin ill = (f3 == 3 || f3 >= 6); use1 = 1; used = 1; alu = 4'h0; s2 = 1;
                   wb = 2'd1; wr = 1; ls = f3; end
      7'h23: begin ill = (f3 > 2); use1 = 1; use2 = 1; alu = 4'h0; s2 = 1; wm = 1;
                   ls = f3; sx = 3'd6; end
      7'h13: begin
        ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
        use1 = 1; used = 1; s2 = 1; wr = 1; alu = ref_alu(f3, f3 == 5 && f7 == 7'h20);
      end
      7'h33: begin
        if (f7 == 7'h01 && M_EN) begin
          use1 = 1; use2 = 1; used = 1; wr = 1; mv = 1; mo = f3;
        end else begin
          ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
          use1 = 1; use2 = 1; used = 1; wr = 1; alu = ref_alu(f3, f7 == 7'h20);
        end
      end
      default: ill = (ins != 32'h0);
    endcase
    if (ill) return {15'd0, 4'he, 3'b010, 3'd0, 3'd0, 2'd0, 6'd0, 1'b1, 1'b0, 3'd0};
    rs1 = use1 ? ins[19:15] : 5'd0;
    rs2 = use2 ? ins[24:20] : 5'd0;
    rd  = used ? ins[11:7]  : 5'd0;
    return {rs1, rs2, rd, alu, br, ls, sx, wb, jmp, jt, s1, s2, wr, wm, ill, mv, mo};
  endfunction

  // Occupancy model and expected-queue push on every accepted instruction.
  int m_cnt  = 0;
  bit m_slot = 1'b0;
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    bit enq, deq;
    if (chk_en) begin
      check("count", vec_t'(count), vec_t'(m_cnt));
      check("in_ready", vec_t'(in_ready), vec_t'(m_cnt != DEPTH));
      check("out_valid", vec_t'(out_valid), vec_t'(m_slot));
    end
    if (!rst_n || flush) begin
      m_cnt = 0; m_slot = 1'b0; exp_q.delete();
    end else begin
      enq = in_valid && (m_cnt != DEPTH);
      deq = (m_cnt > 0) && (!m_slot || out_ready);
      if (enq) exp_q.push_back({in_pc, ref_decode(in_instr)});
      if (deq) m_slot = 1'b1;
      else if (out_ready) m_slot = 1'b0;
      m_cnt = m_cnt + int'(enq) - int'(deq);
    end
    if (!rst_n) chk_en = 1'b1;
  end

  // Monitor: pops on every output handshake and checks slot stability under backpressure.
  bit   hold_v = 1'b0;
  vec_t hold_val;
  always @(negedge clk) begin
    if (hold_v) check("slot_stable", {out_pc, dut_fields}, hold_val);
    if (rst_n && !flush && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", vec_t'(out_valid), vec_t'(0));
      else check("data", {out_pc, dut_fields}, exp_q.pop_front());
    end
    hold_v   = rst_n && !flush && out_valid === 1'b1 && !out_ready;
    hold_val = {out_pc, dut_fields};
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    push(ins, pc);
    cyc();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h7f, 7'h0b};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 11)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 30) == 0) r = 32'h0;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int waited;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    check("rst_count", vec_t'(count), vec_t'(0));
    check("rst_in_ready", vec_t'(in_ready), vec_t'(1));
    check("rst_out_valid", vec_t'(out_valid), vec_t'(0));
    check("rst_fields", vec_t'(dut_fields), vec_t'(RESET_FIELDS));
    check("rst_pc", vec_t'(out_pc), vec_t'(0));

    // addi x1, x0, 5
    out_ready = 1'b1;
    run_one(32'h00500093, 32'h100);
    check("addi_valid", vec_t'(out_valid), vec_t'(1));
    check("addi_rd", vec_t'(out_rd), vec_t'(1));
    check("addi_rs1", vec_t'(out_rs1), vec_t'(0));
    check("addi_alu", vec_t'(out_alu_ctrl), vec_t'(4'b0000));
    check("addi_src2", vec_t'(out_alu_src2), vec_t'(1));
    check("addi_we_reg", vec_t'(out_we_reg), vec_t'(1));
    check("addi_sext", vec_t'(out_sext_type), vec_t'(3'b000));
    check("addi_pc", vec_t'(out_pc), vec_t'(32'h100));

    run_one(32'h0000A003, 32'h200);
    check("lw_illegal", vec_t'(out_illegal), vec_t'(0));
    check("lw_ls", vec_t'(out_ls_type), vec_t'(3'b010));
    run_one(32'h0000B003, 32'h204);
    check("ld_illegal", vec_t'(out_illegal), vec_t'(1));
    check("ld_we_reg", vec_t'(out_we_reg), vec_t'(0));
    check("ld_alu", vec_t'(out_alu_ctrl), vec_t'(4'b1110));
    check("ld_pc", vec_t'(out_pc), vec_t'(32'h204));
    run_one(32'h00000000, 32'h208);
    check("bubble_illegal", vec_t'(out_illegal), vec_t'(0));
    check("bubble_we_reg", vec_t'(out_we_reg), vec_t'(0));

    run_one(32'hFE208EE3, 32'h300);
    check("beq_branch", vec_t'(out_branch), vec_t'(3'b000));
    check("beq_rd", vec_t'(out_rd), vec_t'(0));
    check("beq_we_reg", vec_t'(out_we_reg), vec_t'(0));
    check("beq_sext", vec_t'(out_sext_type), vec_t'(3'b001));
    run_one(32'h008000EF, 32'h304);
    check("jal_jump", vec_t'(out_jump), vec_t'(1));
    check("jal_type", vec_t'(out_jump_type), vec_t'(1));
    check("jal_wb", vec_t'(out_wb_ctrl), vec_t'(2'b11));
    check("jal_sext", vec_t'(out_sext_type), vec_t'(3'b010));

    run_one(32'h022081B3, 32'h400);
    check("mul_md_valid", vec_t'(out_md_valid), vec_t'(M_EN));
    check("mul_md_op", vec_t'(out_md_op), vec_t'(0));
    check("mul_illegal", vec_t'(out_illegal), vec_t'(!M_EN));
    cyc();

    // Backpressure: fill slot plus queue, then offer one more.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(32'h00100093 + (i << 7), 32'h1000 + 4 * i);
    check("full_count", vec_t'(count), vec_t'(DEPTH));
    check("full_in_ready", vec_t'(in_ready), vec_t'(0));
    check("full_slot_pc", vec_t'(out_pc), vec_t'(32'h1000));
    in_valid = 1'b1; in_instr = 32'h00C00193; in_pc = 32'h2000;
    repeat (3) cyc();
    check("full_hold_count", vec_t'(count), vec_t'(DEPTH));
    check("full_hold_pc", vec_t'(out_pc), vec_t'(32'h1000));
    out_ready = 1'b1;
    cyc();
    check("full_deq_count", vec_t'(count), vec_t'(DEPTH - 1));
    check("full_reassert", vec_t'(in_ready), vec_t'(1));
    cyc();
    in_valid = 1'b0;
    waited = 0;
    while ((count != 0 || out_valid) && waited < 30) begin cyc(); waited++; end
    check("drain_done", vec_t'(waited < 30), vec_t'(1));
    check("drain_empty", vec_t'(exp_q.size()), vec_t'(0));

    // Flush with three queued and a new instruction offered in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h00208133, 32'h3000 + 4 * i);
    check("preflush_count", vec_t'(count), vec_t'(3));
    in_valid = 1'b1; in_instr = 32'h00A00113; in_pc = 32'hF1F0; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", vec_t'(count), vec_t'(0));
    check("flush_out_valid", vec_t'(out_valid), vec_t'(0));
    check("flush_in_ready", vec_t'(in_ready), vec_t'(1));
    out_ready = 1'b1;
    repeat (4) cyc();
    check("flush_no_output", vec_t'(out_valid), vec_t'(0));

    // Randomized traffic with occasional flush and one reset.
    in_pc = 32'h8000;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready && !flush && rst_n;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
        in_pc    = in_pc + 4;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      rst_n     = (c != 700);
    end
    flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) cyc();
    check("rand_drained", vec_t'(exp_q.size()), vec_t'(0));

    // Reset while busy clears everything, including the output fields.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h401101B3, 32'h5000 + 4 * i);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("midrst_count", vec_t'(count), vec_t'(0));
    check("midrst_out_valid", vec_t'(out_valid), vec_t'(0));
    check("midrst_fields", vec_t'(dut_fields), vec_t'(RESET_FIELDS));
    check("midrst_pc", vec_t'(out_pc), vec_t'(0));
    out_ready = 1'b1;
    repeat (4) cyc();
    check("final_empty", vec_t'(exp_q.size()), vec_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
